// File: rtl/bfly_pkg.sv
// Shared constants and helpers for the radix-2 IFFT butterfly datapath.
package bfly_pkg;

  localparam int DATA_W = 36;   // real/imag data word width
  localparam int TW_W   = 18;   // twiddle coefficient width (signed Q2.16)
  localparam int TW_F   = 16;   // twiddle fraction bits
  localparam int ACC_W  = 128;  // working width for round/saturate

  // round(65536*cos(2*pi*k/32)) and round(65536*sin(2*pi*k/32)), k = 0..15
  localparam int TW_RE [0:15] = '{
     65536,  64277,  60547,  54491,  46341,  36410,  25080,  12785,
         0, -12785, -25080, -36410, -46341, -54491, -60547, -64277
  };
  localparam int TW_IM [0:15] = '{
         0,  12785,  25080,  36410,  46341,  54491,  60547,  64277,
     65536,  64277,  60547,  54491,  46341,  36410,  25080,  12785
  };

  // Round to nearest (add half LSB, floor shift) then clamp to a w-bit signed range.
  function automatic logic signed [ACC_W-1:0] round_sat(
    input logic signed [ACC_W-1:0] x,
    input int unsigned             frac,
    input int unsigned             w
  );
    logic signed [ACC_W-1:0] one, half, y, hi, lo;
    one  = {{(ACC_W-1){1'b0}}, 1'b1};
    half = one <<< (frac - 1);
    y    = (x + half) >>> frac;
    hi   = (one <<< (w - 1)) - one;
    lo   = -(one <<< (w - 1));
    if (y > hi)
      y = hi;
    else if (y < lo)
      y = lo;
    return y;
  endfunction

endpackage

// File: rtl/bfly2_cmul_const.sv
// Constant complex multiplier by twiddle K with round-to-nearest, saturation
// and one output register.
module cmul_const
  import bfly_pkg::*;
#(
  parameter int W   = DATA_W,
  parameter int TWW = TW_W,
  parameter int K   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] dr,
  input  logic signed [W-1:0] di,
  output logic signed [W-1:0] pr,
  output logic signed [W-1:0] pi
);

  // Full-precision product width: W x TWW product plus one bit for the add/sub.
  localparam int PW = W + TWW + 1;
  localparam logic signed [PW-1:0] CR = PW'(TW_RE[K]);
  localparam logic signed [PW-1:0] CI = PW'(TW_IM[K]);

  logic signed [PW-1:0] xr, xi, acc_r, acc_i;

  // Exact complex product (dr + j*di) * (CR + j*CI) at full precision.
  always_comb begin
    xr    = PW'(dr);
    xi    = PW'(di);
    acc_r = xr * CR - xi * CI;
    acc_i = xr * CI + xi * CR;
  end

  // Drop the Q16 fraction with rounding and clamp into the W-bit output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr <= '0;
      pi <= '0;
    end else begin
      pr <= W'(round_sat(ACC_W'(acc_r), TW_F, W));
      pi <= W'(round_sat(ACC_W'(acc_i), TW_F, W));
    end
  end

endmodule

// File: rtl/bfly2.sv
// Pipelined radix-2 DIF butterfly: halved sum and halved, twiddle-rotated
// difference, two cycles of latency, one butterfly per clock.
module bfly2
  import bfly_pkg::*;
#(
  parameter int W   = DATA_W,
  parameter int K   = 0,
  parameter int TWW = TW_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] di1r,
  input  logic signed [W-1:0] di1i,
  input  logic signed [W-1:0] di2r,
  input  logic signed [W-1:0] di2i,
  output logic signed [W-1:0] do1r,
  output logic signed [W-1:0] do1i,
  output logic signed [W-1:0] do2r,
  output logic signed [W-1:0] do2i
);

  if (K < 0 || K > 15) begin : g_bad_k
    $error("bfly2: twiddle index K=%0d outside 0..15", K);
  end

  logic signed [W:0]   sum_r, sum_i, dif_r, dif_i;
  logic signed [W-1:0] s_r, s_i, d_r, d_i;
  logic signed [W-1:0] q_r, q_i;

  // Sum and difference one bit wider so they never overflow.
  always_comb begin
    sum_r = {di1r[W-1], di1r} + {di2r[W-1], di2r};
    sum_i = {di1i[W-1], di1i} + {di2i[W-1], di2i};
    dif_r = {di1r[W-1], di1r} - {di2r[W-1], di2r};
    dif_i = {di1i[W-1], di1i} - {di2i[W-1], di2i};
  end

  // Stage 1: floor-halve back to W bits; the halved value always fits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r <= '0;
      s_i <= '0;
      d_r <= '0;
      d_i <= '0;
    end else begin
      s_r <= W'(sum_r >>> 1);
      s_i <= W'(sum_i >>> 1);
      d_r <= W'(dif_r >>> 1);
      d_i <= W'(dif_i >>> 1);
    end
  end

  // Stage 2, sum path: pure delay to stay aligned with the multiplier register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= '0;
      q_i <= '0;
    end else begin
      q_r <= s_r;
      q_i <= s_i;
    end
  end

  cmul_const #(
    .W   (W),
    .TWW (TWW),
    .K   (K)
  ) u_cmul (
    .clk (clk),
    .rst (rst),
    .dr  (d_r),
    .di  (d_i),
    .pr  (do2r),
    .pi  (do2i)
  );

  assign do1r = q_r;
  assign do1i = q_i;

endmodule

// File: tb/tb_bfly2.sv
// Bench for bfly2: one instance per twiddle index, shared stimulus,
// directed vectors plus random streaming against an arithmetic model.
module tb_bfly2;

  localparam int W = 36;

  typedef struct {
    longint ar, ai, br, bi;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [W-1:0] i1r, i1i, i2r, i2i;
  logic signed [W-1:0] o1r [16];
  logic signed [W-1:0] o1i [16];
  logic signed [W-1:0] o2r [16];
  logic signed [W-1:0] o2i [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 16; g++) begin : g_dut
    bfly2 #(
      .W   (W),
      .K   (g),
      .TWW (18)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .di1r (i1r),
      .di1i (i1i),
      .di2r (i2r),
      .di2i (i2i),
      .do1r (o1r[g]),
      .do1i (o1i[g]),
      .do2r (o2r[g]),
      .do2i (o2i[g])
    );
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (64'sd1 <<< (W - 1)) - 1;
    lo = -(64'sd1 <<< (W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: halve with floor, multiply by the rounded Q16 twiddle
  // exp(+j*2*pi*k/32), round to nearest, saturate.
  function automatic void model(input int k, input vec_t v,
                                output longint e1r, output longint e1i,
                                output longint e2r, output longint e2i);
    real    ang;
    longint cr, ci, dr, di;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / 32.0;
    cr  = longint'($floor(65536.0 * $cos(ang) + 0.5));
    ci  = longint'($floor(65536.0 * $sin(ang) + 0.5));
    e1r = (v.ar + v.br) >>> 1;
    e1i = (v.ai + v.bi) >>> 1;
    dr  = (v.ar - v.br) >>> 1;
    di  = (v.ai - v.bi) >>> 1;
    e2r = sat((dr * cr - di * ci + 32768) >>> 16);
    e2i = sat((dr * ci + di * cr + 32768) >>> 16);
  endfunction

  task automatic check_zero(input string tag);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s k%0d do1r", tag, k), o1r[k], 0);
      check($sformatf("%s k%0d do1i", tag, k), o1i[k], 0);
      check($sformatf("%s k%0d do2r", tag, k), o2r[k], 0);
      check($sformatf("%s k%0d do2i", tag, k), o2i[k], 0);
    end
  endtask

  // Reset, hold one vector, release, and leave the bench where outputs are valid.
  task automatic apply_hold(input logic [W-1:0] ar, input logic [W-1:0] ai,
                            input logic [W-1:0] br, input logic [W-1:0] bi);
    @(negedge clk);
    rst = 1'b0;
    i1r = ar; i1i = ai; i2r = br; i2i = bi;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic rand_word(output logic signed [W-1:0] v);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       v = {1'b0, {(W-1){1'b1}}};
      1:       v = {1'b1, {(W-1){1'b0}}};
      2:       v = W'(r[15:0]);
      default: v = r[W-1:0];
    endcase
  endtask

  initial begin
    vec_t   q[$];
    vec_t   v, e;
    longint e1r, e1i, e2r, e2i;

    // Reset held with nonzero inputs.
    rst = 1'b0;
    i1r = 36'h123456789; i1i = 36'h0FEDCBA98;
    i2r = 36'h876543210; i2i = 36'h13579BDF0;
    repeat (5) @(negedge clk);
    check_zero("rst_hold");

    // K=0 and K=8 on the reference vector.
    apply_hold(36'h111111111, 36'h222222222, 36'h333333333, 36'h444444444);
    check("k0 do1r", o1r[0], sx(36'h222222222));
    check("k0 do1i", o1i[0], sx(36'h333333333));
    check("k0 do2r", o2r[0], sx(36'hEEEEEEEEF));
    check("k0 do2i", o2i[0], sx(36'hEEEEEEEEF));
    check("k8 do1r", o1r[8], sx(36'h222222222));
    check("k8 do1i", o1i[8], sx(36'h333333333));
    check("k8 do2r", o2r[8], sx(36'h111111111));
    check("k8 do2i", o2i[8], sx(36'hEEEEEEEEF));

    // K=4: 32768*46341/65536 = 23170.5, rounds up.
    apply_hold(36'd65536, 36'd0, 36'd0, 36'd0);
    check("k4 do1r", o1r[4], 32768);
    check("k4 do1i", o1i[4], 0);
    check("k4 do2r", o2r[4], 23171);
    check("k4 do2i", o2i[4], 23171);

    // Extremes.
    apply_hold(36'h7FFFFFFFF, 36'd0, 36'h7FFFFFFFF, 36'd0);
    check("max do1r", o1r[0], sx(36'h7FFFFFFFF));
    check("max do2r", o2r[0], 0);
    apply_hold(36'h800000000, 36'h800000000, 36'h7FFFFFFFF, 36'h7FFFFFFFF);
    check("min k0 do2r", o2r[0], sx(36'h800000000));
    check("min k0 do1r", o1r[0], -1);
    check("min k8 do2r", o2r[8], sx(36'h7FFFFFFFF));
    check("min k8 do2i", o2i[8], sx(36'h800000000));

    // Random streaming: a vector driven at one falling edge is checked two
    // falling edges later.
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (q.size() == 2) begin
        e = q.pop_front();
        for (int k = 0; k < 16; k++) begin
          model(k, e, e1r, e1i, e2r, e2i);
          check($sformatf("stream k%0d do1r", k), o1r[k], e1r);
          check($sformatf("stream k%0d do1i", k), o1i[k], e1i);
          check($sformatf("stream k%0d do2r", k), o2r[k], e2r);
          check($sformatf("stream k%0d do2i", k), o2i[k], e2i);
        end
      end
      rand_word(i1r); rand_word(i1i); rand_word(i2r); rand_word(i2i);
      v.ar = i1r; v.ai = i1i; v.br = i2r; v.bi = i2i;
      q.push_back(v);
      rst = 1'b1;
      @(negedge clk);
    end

    // Asynchronous reset between edges clears outputs before the next edge.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("rst_async");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
